// File: rtl/turn_ctrl.sv
// Battle-phase sequencer: drives the enemy block's state/turn, tracks HP, decides WIN/GAMEOVER.
// All outputs registered (one cycle after trigger); optional enemy watchdog via TURN_CTRL_WATCHDOG_EN.
module turn_ctrl #(
    parameter int MAX_TURN       = 8,
    parameter int HP_INIT        = 20,
    parameter int INTRO_CYCLES   = 650000,
    parameter int PLAYER_TIMEOUT = 6500000,
    parameter int ENEMY_TIMEOUT  = 65000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_in,
    input  logic       player_done_in,
    input  logic       enemy_busy_in,
    input  logic       enemy_finished_in,
    input  logic       hit_in,
    output logic [3:0] state_out,
    output logic [3:0] turn_out,
    output logic [7:0] hp_out,
    output logic       game_over_out,
    output logic       win_out,
    output logic       watchdog_out
);
    localparam logic [3:0] S_IDLE     = 4'b0000;
    localparam logic [3:0] S_INTRO    = 4'b0001;
    localparam logic [3:0] S_PLAYER   = 4'b0010;
    localparam logic [3:0] S_CHECK    = 4'b0100;
    localparam logic [3:0] S_ENEMY    = 4'b1000;
    localparam logic [3:0] S_WIN      = 4'b1110;
    localparam logic [3:0] S_GAMEOVER = 4'b1111;

    // One shared phase counter, sized for the longest phase limit.
    localparam int CNT_MAX = (INTRO_CYCLES > PLAYER_TIMEOUT) ?
                             ((INTRO_CYCLES > ENEMY_TIMEOUT) ? INTRO_CYCLES : ENEMY_TIMEOUT) :
                             ((PLAYER_TIMEOUT > ENEMY_TIMEOUT) ? PLAYER_TIMEOUT : ENEMY_TIMEOUT);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INTRO_LAST  = CNT_W'(INTRO_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLAYER_LAST = CNT_W'(PLAYER_TIMEOUT - 1);
    localparam logic [3:0]       TURN_LAST   = 4'(MAX_TURN - 1);

    logic [3:0]       state_q, state_d;
    logic [3:0]       turn_q, turn_d;
    logic [7:0]       hp_q, hp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             go_q, go_d;
    logic             win_q, win_d;
    logic             hit_abort;
    logic             busy_unused;

    // Busy is informational: the finished pulse already implies it has fallen.
    assign busy_unused = enemy_busy_in;
    assign hit_abort   = (state_q == S_ENEMY) && hit_in && (hp_q <= 8'd1);

`ifdef TURN_CTRL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] ENEMY_LAST = CNT_W'(ENEMY_TIMEOUT - 1);
    logic wd_q, wd_d;
    assign watchdog_out = wd_q;
`else
    assign watchdog_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            turn_q  <= '0;
            hp_q    <= '0;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            win_q   <= 1'b0;
`ifdef TURN_CTRL_WATCHDOG_EN
            wd_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            hp_q    <= hp_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
            win_q   <= win_d;
`ifdef TURN_CTRL_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_WIN, S_GAMEOVER: if (start_in) state_d = S_INTRO;
            S_INTRO:  if (cnt_q == INTRO_LAST) state_d = S_PLAYER;
            S_PLAYER: if (player_done_in || cnt_q == PLAYER_LAST) state_d = S_ENEMY;
            S_ENEMY: begin
                // A fatal hit beats a same-cycle finished pulse.
                if (hit_abort)              state_d = S_GAMEOVER;
                else if (enemy_finished_in) state_d = S_CHECK;
`ifdef TURN_CTRL_WATCHDOG_EN
                else if (cnt_q == ENEMY_LAST) state_d = S_CHECK;
`endif
            end
            S_CHECK:  state_d = (turn_q == TURN_LAST) ? S_WIN : S_PLAYER;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        turn_d = turn_q;
        hp_d   = hp_q;
        cnt_d  = '0;
`ifdef TURN_CTRL_WATCHDOG_EN
        wd_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_WIN, S_GAMEOVER: begin
                if (start_in) begin
                    hp_d   = 8'(HP_INIT);
                    turn_d = '0;
                end
            end
            S_INTRO:  if (state_d == S_INTRO)  cnt_d = cnt_q + CNT_W'(1);
            S_PLAYER: if (state_d == S_PLAYER) cnt_d = cnt_q + CNT_W'(1);
            S_ENEMY: begin
                if (hit_in) hp_d = (hp_q == 8'd0) ? 8'd0 : hp_q - 8'd1;
`ifdef TURN_CTRL_WATCHDOG_EN
                if (state_d == S_ENEMY) cnt_d = cnt_q + CNT_W'(1);
                wd_d = (state_d == S_CHECK) && !enemy_finished_in;
`endif
            end
            S_CHECK:  if (state_d == S_PLAYER) turn_d = turn_q + 4'd1;
            default:  ;
        endcase
        go_d  = (state_d == S_GAMEOVER);
        win_d = (state_d == S_WIN);
    end

    assign state_out     = state_q;
    assign turn_out      = turn_q;
    assign hp_out        = hp_q;
    assign game_over_out = go_q;
    assign win_out       = win_q;
endmodule

// File: tb/tb_turn_ctrl.sv
// Directed bench for turn_ctrl: a cycle table for a win game and a game-over game, then timeout/reset sequences.
module tb_turn_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_in = 1'b0, player_done_in = 1'b0, enemy_busy_in = 1'b0;
    logic       enemy_finished_in = 1'b0, hit_in = 1'b0;
    logic [3:0] state_out, turn_out;
    logic [7:0] hp_out;
    logic       game_over_out, win_out, watchdog_out;

    int n_checks = 0;
    int n_fail   = 0;

    turn_ctrl #(
        .MAX_TURN(2), .HP_INIT(3), .INTRO_CYCLES(4),
        .PLAYER_TIMEOUT(10), .ENEMY_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .player_done_in(player_done_in),
        .enemy_busy_in(enemy_busy_in), .enemy_finished_in(enemy_finished_in), .hit_in(hit_in),
        .state_out(state_out), .turn_out(turn_out), .hp_out(hp_out),
        .game_over_out(game_over_out), .win_out(win_out), .watchdog_out(watchdog_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, pd, fin, hit;
        logic [3:0] e_state, e_turn;
        logic [7:0] e_hp;
        logic       e_go, e_win;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, pd, fin, hit, input logic [3:0] es, et,
                                input logic [7:0] eh, input logic eg, ew);
        vec_t v;
        v.st = st; v.pd = pd; v.fin = fin; v.hit = hit;
        v.e_state = es; v.e_turn = et; v.e_hp = eh; v.e_go = eg; v.e_win = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] es, et, input logic [7:0] eh,
                             input logic eg, ew, ewd);
        chk({tag, " state"}, 32'(state_out), 32'(es));
        chk({tag, " turn"},  32'(turn_out),  32'(et));
        chk({tag, " hp"},    32'(hp_out),    32'(eh));
        chk({tag, " go"},    32'(game_over_out), 32'(eg));
        chk({tag, " win"},   32'(win_out),   32'(ew));
        chk({tag, " wd"},    32'(watchdog_out), 32'(ewd));
    endtask

    // Apply current inputs on the next edge, then clear them and settle.
    task automatic step();
        @(posedge clk);
        #1;
        start_in = 1'b0; player_done_in = 1'b0; enemy_finished_in = 1'b0; hit_in = 1'b0;
    endtask

    initial begin
        // start, 3 more intro, player: hit/start/fin ignored, done; enemy: hit, fin -> check -> turn 1
        vecs.push_back(mk(1,0,0,0, 4'h1,0,3,0,0));
        vecs.push_back(mk(0,0,0,0, 4'h1,0,3,0,0));
        vecs.push_back(mk(0,0,0,0, 4'h1,0,3,0,0));
        vecs.push_back(mk(0,0,0,0, 4'h1,0,3,0,0));
        vecs.push_back(mk(0,0,0,0, 4'h2,0,3,0,0));
        vecs.push_back(mk(0,0,0,1, 4'h2,0,3,0,0));
        vecs.push_back(mk(1,0,0,0, 4'h2,0,3,0,0));
        vecs.push_back(mk(0,0,1,0, 4'h2,0,3,0,0));
        vecs.push_back(mk(0,1,0,0, 4'h8,0,3,0,0));
        vecs.push_back(mk(0,1,0,0, 4'h8,0,3,0,0));
        vecs.push_back(mk(0,0,0,1, 4'h8,0,2,0,0));
        vecs.push_back(mk(0,0,1,0, 4'h4,0,2,0,0));
        vecs.push_back(mk(0,0,0,1, 4'h2,1,2,0,0));
        vecs.push_back(mk(0,1,0,0, 4'h8,1,2,0,0));
        vecs.push_back(mk(0,0,1,0, 4'h4,1,2,0,0));
        vecs.push_back(mk(0,0,0,0, 4'hE,1,2,0,1));
        vecs.push_back(mk(0,0,1,0, 4'hE,1,2,0,1));
        // restart from WIN, then lose all HP; the fatal hit coincides with finished
        vecs.push_back(mk(1,0,0,0, 4'h1,0,3,0,0));
        vecs.push_back(mk(0,0,0,0, 4'h1,0,3,0,0));
        vecs.push_back(mk(0,0,0,0, 4'h1,0,3,0,0));
        vecs.push_back(mk(0,0,0,0, 4'h1,0,3,0,0));
        vecs.push_back(mk(0,0,0,0, 4'h2,0,3,0,0));
        vecs.push_back(mk(0,1,0,0, 4'h8,0,3,0,0));
        vecs.push_back(mk(0,0,0,1, 4'h8,0,2,0,0));
        vecs.push_back(mk(0,0,0,1, 4'h8,0,1,0,0));
        vecs.push_back(mk(0,0,1,1, 4'hF,0,0,1,0));
        vecs.push_back(mk(0,0,1,0, 4'hF,0,0,1,0));
        vecs.push_back(mk(0,0,0,1, 4'hF,0,0,1,0));
        vecs.push_back(mk(1,0,0,0, 4'h1,0,3,0,0));

        #2;
        check_all("reset", 4'h0, 4'h0, 8'h0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_all("idle", 4'h0, 4'h0, 8'h0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            start_in = vecs[i].st; player_done_in = vecs[i].pd;
            enemy_finished_in = vecs[i].fin; hit_in = vecs[i].hit;
            enemy_busy_in = (state_out == 4'h8);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_turn,
                      vecs[i].e_hp, vecs[i].e_go, vecs[i].e_win, 1'b0);
        end

        // Intro already one cycle in; player phase times out after 10 cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("intro hold", 32'(state_out), 32'h1);
        end
        step();
        chk("intro->player", 32'(state_out), 32'h2);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("player hold", 32'(state_out), 32'h2);
        end
        step();
        check_all("player timeout", 4'h8, 4'h0, 8'd3, 0, 0, 0);

`ifdef TURN_CTRL_WATCHDOG_EN
        for (int i = 0; i < 15; i++) begin
            step();
            chk("enemy hold", 32'(state_out), 32'h8);
            chk("wd quiet", 32'(watchdog_out), 32'h0);
        end
        step();
        check_all("watchdog fire", 4'h4, 4'h0, 8'd3, 0, 0, 1);
        step();
        check_all("after watchdog", 4'h2, 4'h1, 8'd3, 0, 0, 0);
        player_done_in = 1'b1;
        step();
        chk("enemy again", 32'(state_out), 32'h8);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk("enemy wait", 32'(state_out), 32'h8);
            chk("wd tied", 32'(watchdog_out), 32'h0);
        end
`endif

        // Asynchronous reset mid-ENEMY, away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        check_all("async reset", 4'h0, 4'h0, 8'h0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post-reset idle", 32'(state_out), 32'h0);
        end
        start_in = 1'b1;
        step();
        check_all("restart", 4'h1, 4'h0, 8'd3, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
